// File: rtl/sdfm_bus_master.sv
// Parallel-bus master for the SDFM register file: queues up to two commands and runs each
// as a SETUP / STROBE / HOLD cycle on WR/RD/ADDR/DATA, reporting completion on rsp_*.
`timescale 1ns / 1ps

module sdfm_bus_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        EXTCLK,
  input  logic        EXTRSTn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wr,
  input  logic [15:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic        rsp_wr,
  output logic [31:0] rsp_rdata,
  output logic        busy,
  output logic        WR,
  output logic        RD,
  output logic [15:0] ADDR,
  inout  wire  [31:0] DATA
);

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StHold} state_e;

  // The down-counter holds "remaining cycles minus one" for the current phase.
  localparam logic [3:0] SetupLoad  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HoldLoad   = 4'(HOLD_CYC - 1);

  cmd_t        fifo_q [2];
  logic        wptr_q, rptr_q;
  logic [1:0]  fifo_cnt_q;
  logic        push, pop;
  cmd_t        head;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        leave_strobe;

  logic        txn_wr_q, txn_wr_d;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;

  logic        wr_q, rd_q, data_oe_q;
  logic        rsp_valid_q, rsp_wr_q;
  logic [31:0] rsp_rdata_q;

  assign head      = fifo_q[rptr_q];
  assign cmd_ready = (fifo_cnt_q != 2'd2);
  assign push      = cmd_valid && cmd_ready;

  // Command FIFO
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= '{wr: cmd_wr, addr: cmd_addr, wdata: cmd_wdata};
        wptr_q         <= ~wptr_q;
      end
      if (pop) begin
        rptr_q <= ~rptr_q;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Phase sequencer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    leave_strobe = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (fifo_cnt_q != 2'd0) begin
          pop     = 1'b1;
          state_d = StSetup;
          cnt_d   = SetupLoad;
        end
      end
      StSetup: begin
        if (cnt_q == 4'd0) begin
          state_d = StStrobe;
          cnt_d   = StrobeLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StStrobe: begin
        if (cnt_q == 4'd0) begin
          leave_strobe = 1'b1;
          state_d      = StHold;
          cnt_d        = HoldLoad;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
    txn_wr_d = pop ? head.wr : txn_wr_q;
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      txn_wr_q <= 1'b0;
      addr_q   <= 16'h0000;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      txn_wr_q <= txn_wr_d;
      if (pop) begin
        addr_q  <= head.addr;
        wdata_q <= head.wdata;
      end
    end
  end

  // Strobes and data enable are registered from the next state so the pins never glitch.
  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      wr_q      <= (state_d == StStrobe) && txn_wr_d;
      rd_q      <= (state_d == StStrobe) && !txn_wr_d;
      data_oe_q <= (state_d != StIdle) && txn_wr_d;
    end
  end

  always_ff @(posedge EXTCLK or negedge EXTRSTn) begin
    if (!EXTRSTn) begin
      rsp_valid_q <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      rsp_valid_q <= leave_strobe;
      if (leave_strobe) begin
        rsp_wr_q <= txn_wr_q;
        if (!txn_wr_q) begin
          rsp_rdata_q <= DATA;
        end
      end
    end
  end

  assign DATA      = data_oe_q ? wdata_q : 32'hzzzz_zzzz;
  assign WR        = wr_q;
  assign RD        = rd_q;
  assign ADDR      = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_wr    = rsp_wr_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (fifo_cnt_q != 2'd0) || (state_q != StIdle);

endmodule

// File: doc/sdfm_bus_master.md
SDFM_BUS_MASTER -- requirements
Module: sdfm_bus_master

Interface
- REQ-001 SHALL have parameter SETUP_CYC, default 1, the number of cycles (1..15) for which ADDR (and write DATA) are stable before the strobe.
- REQ-002 SHALL have parameter STROBE_CYC, default 2, the number of cycles (1..15) for which WR or RD is high.
- REQ-003 SHALL have parameter HOLD_CYC, default 1, the number of cycles (1..15) for which ADDR (and write DATA) are held after the strobe.
- REQ-004 EXTCLK  in  1  clock; all logic is rising-edge.
- REQ-005 EXTRSTn  in  1  asynchronous, active-low reset.
- REQ-006 cmd_valid  in  1  command request.
- REQ-007 cmd_ready  out  1  command accept; equals !fifo_full.
- REQ-008 cmd_wr  in  1  1=write, 0=read.
- REQ-009 cmd_addr  in  16  target address (ADDR[15:8]=device, ADDR[7:0]=register).
- REQ-010 cmd_wdata  in  32  write data.
- REQ-011 rsp_valid  out  1  one-cycle transaction-complete pulse.
- REQ-012 rsp_wr  out  1  type of the completed transaction.
- REQ-013 rsp_rdata  out  32  captured read data; holds its value until the next read completes.
- REQ-014 busy  out  1  high when the FIFO is non-empty or the FSM is not in IDLE.
- REQ-015 WR  out  1  bus write strobe.
- REQ-016 RD  out  1  bus read strobe.
- REQ-017 ADDR  out  16  bus address.
- REQ-018 DATA  inout  32  bus data; driven only during write transactions, otherwise high-Z.

Function
- REQ-019 Command FIFO: 2 entries of {wr, addr[15:0], wdata[31:0]}; a push occurs on an edge where cmd_valid && cmd_ready.
- REQ-020 FIFO rules: a push and a pop in the same edge are both performed; a push when full cannot occur; a pop when empty never occurs.
- REQ-021 FSM states: IDLE, SETUP, STROBE, HOLD; a single 4-bit down-counter is loaded on every state entry.
- REQ-022 IDLE: when the FIFO count is greater than 0, pop the head entry into the transaction registers and enter SETUP on the same edge.
- REQ-023 SETUP: ADDR=addr; DATA is driven with wdata if wr, else high-Z; WR=RD=0; the state lasts SETUP_CYC cycles, then goes to STROBE.
- REQ-024 STROBE: WR=wr or RD=!wr; ADDR and DATA are unchanged; the state lasts STROBE_CYC cycles, then goes to HOLD.
- REQ-025 Read capture: on the edge leaving STROBE, rsp_rdata <= DATA.
- REQ-026 Response: on the edge leaving STROBE, rsp_valid <= 1 and rsp_wr <= wr; rsp_valid is high for exactly 1 cycle.
- REQ-027 HOLD: WR=RD=0; ADDR held; write DATA held; the state lasts HOLD_CYC cycles, then goes to IDLE.
- REQ-028 IDLE always lasts at least 1 cycle between transactions, giving a bus turnaround; DATA is high-Z in IDLE; ADDR retains the last value.
- REQ-029 WR and RD SHALL never both be high; DATA SHALL never be driven while RD is high.
- REQ-030 WR, RD and the DATA output enable SHALL be driven from registers (glitch-free).
- REQ-031 Minimum transaction length is SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles, including IDLE.
- REQ-032 Commands complete strictly in acceptance order.

Reset
- REQ-033 EXTRSTn low SHALL immediately force the following:
  - WR=RD=0, DATA high-Z, ADDR=16'h0000;
  - rsp_valid=0, rsp_wr=0, rsp_rdata=32'h0;
  - busy=0, cmd_ready=1;
  - FIFO empty, FSM in IDLE, counter 0.
- REQ-034 Reset asserted mid-transaction SHALL abort the transaction and discard queued commands, with no rsp_valid.
- REQ-035 After reset deassertion, the first command accepted SHALL start normally.

Verification
- REQ-036 Write, default params: write 0x0708 data 0x00000003 accepted at edge E0 -> SETUP at E1; WR high E2..E4; rsp_valid high E4..E5; IDLE at E5; a slave model captures CTL=3.
- REQ-037 Read, default params: read 0x070C with the slave returning 0x1234ABCD -> RD high 2 cycles, DATA never driven by the master, rsp_rdata=0x1234ABCD with rsp_wr=0.
- REQ-038 Back-to-back: 3 commands are offered continuously -> cmd_ready drops after 2 are queued, all 3 complete in order, and there is at least 1 IDLE cycle between strobes.
- REQ-039 Parameter sweep: SETUP_CYC=3, STROBE_CYC=1, HOLD_CYC=2 -> exact phase lengths 3/1/2 and rsp_valid on the edge leaving STROBE.
- REQ-040 Reset mid-strobe: EXTRSTn pulsed low during WR -> WR drops asynchronously, DATA goes high-Z, the FIFO empties, no rsp_valid appears, and the next command works.
- REQ-041 Bus-conflict assertion over all tests: never (WR && RD), and never (RD && DATA driven by the master).
